// File: rtl/case_9_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// case_9_mul_pipe_hs
//   Pipelined multiplier with a valid/ready handshake, intended to sit between
//   HLS stream stages. Each operand can be signed or unsigned. The full
//   product can be right-shifted and is then narrowed to dout_WIDTH bits,
//   either by wrapping or by saturating. Empty pipeline stages keep filling
//   while the output is stalled, and i_ce = 0 freezes every register.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous, active-high reset
//   i_ce         clock enable; 0 freezes all state and blocks transfers
//   i_in_valid   operand beat present
//   o_in_ready   block can accept a beat this cycle
//   i_din0       operand 0 (din0_WIDTH bits)
//   i_din1       operand 1 (din1_WIDTH bits)
//   o_out_valid  result beat present
//   i_out_ready  consumer accepts the result
//   o_dout       narrowed result (dout_WIDTH bits)
//   o_sat_flag   current result beat was clamped (SAT_MODE = 1 only)
// ---------------------------------------------------------------------------
module case_9_mul_pipe_hs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int OUT_SHIFT  = 0,
  parameter int SAT_MODE   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [din0_WIDTH-1:0] i_din0,
  input  logic [din1_WIDTH-1:0] i_din1,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [dout_WIDTH-1:0] o_dout,
  output logic                  o_sat_flag
);

  localparam int N          = NUM_STAGE;
  localparam int P          = din0_WIDTH + din1_WIDTH;
  localparam bit RES_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
  // One guard bit above the wider of product and result, so the clamp
  // limits and the shifted product compare without overflow.
  localparam int XW         = ((P > dout_WIDTH) ? P : dout_WIDTH) + 1;

  localparam logic [XW-1:0] SMAX = {{(XW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [XW-1:0] SMIN = {{(XW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};
  localparam logic [XW-1:0] UMAX = {{(XW-dout_WIDTH){1'b0}}, {dout_WIDTH{1'b1}}};

  logic            w_ext0;
  logic            w_ext1;
  logic [P-1:0]    w_opA;
  logic [P-1:0]    w_opB;
  logic [P-1:0]    w_prod;
  logic [N-1:0]    r_valid;
  logic [N-1:0]    w_rdy;
  logic [N-1:0]    w_load;
  logic [N-1:0]    w_vIn;
  logic [P-1:0]    w_lastIn;
  logic signed [P-1:0] w_shSigned;
  logic [P-1:0]    w_shUnsigned;
  logic [P-1:0]    w_s;
  logic [XW-1:0]   w_sExt;
  logic            w_over;
  logic            w_under;
  logic [dout_WIDTH-1:0] w_doutNext;
  logic            w_satNext;
  logic [dout_WIDTH-1:0] r_dout;
  logic            r_sat;

  // Extending both operands to the full product width makes a plain P-bit
  // multiply exact for every signedness mix: the true product always fits in
  // P bits, so the low P bits of the modular product are the answer.
  assign w_ext0 = (SIGNED0 != 0) & i_din0[din0_WIDTH-1];
  assign w_ext1 = (SIGNED1 != 0) & i_din1[din1_WIDTH-1];
  assign w_opA  = {{din1_WIDTH{w_ext0}}, i_din0};
  assign w_opB  = {{din0_WIDTH{w_ext1}}, i_din1};
  assign w_prod = w_opA * w_opB;

  // A stage can take a new beat when it is empty or when the stage after it
  // is itself moving; this is what lets bubbles collapse under backpressure.
  always_comb begin
    logic chain;
    chain      = ~r_valid[N-1] | i_out_ready;
    w_rdy      = '0;
    w_rdy[N-1] = chain;
    for (int i = N - 2; i >= 0; i--) begin
      chain    = ~r_valid[i] | chain;
      w_rdy[i] = chain;
    end
  end

  assign w_load     = {N{i_ce}} & w_rdy;
  assign o_in_ready = i_ce & w_rdy[0];

  if (N == 1) begin : gVin1
    assign w_vIn = i_in_valid;
  end else begin : gVinN
    assign w_vIn = {r_valid[N-2:0], i_in_valid};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) r_valid[i] <= w_vIn[i];
      end
    end
  end

  // Product registers for stages 1..N-1. The last stage holds only the
  // narrowed result, so a single-stage pipeline narrows the live product.
  if (N > 1) begin : gData
    logic [P-1:0] r_data [N-1];

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        for (int i = 0; i < N - 1; i++) r_data[i] <= '0;
      end else begin
        if (w_load[0] && i_in_valid) r_data[0] <= w_prod;
        for (int i = 1; i < N - 1; i++) begin
          if (w_load[i] && r_valid[i-1]) r_data[i] <= r_data[i-1];
        end
      end
    end

    assign w_lastIn = r_data[N-2];
  end else begin : gNoData
    assign w_lastIn = w_prod;
  end

  assign w_shSigned   = $signed(w_lastIn) >>> OUT_SHIFT;
  assign w_shUnsigned = w_lastIn >> OUT_SHIFT;
  assign w_s          = RES_SIGNED ? w_shSigned : w_shUnsigned;
  assign w_sExt       = {{(XW-P){RES_SIGNED & w_s[P-1]}}, w_s};

  assign w_over  = RES_SIGNED ? ($signed(w_sExt) > $signed(SMAX)) : (w_sExt > UMAX);
  assign w_under = RES_SIGNED & ($signed(w_sExt) < $signed(SMIN));

  always_comb begin
    w_doutNext = w_sExt[dout_WIDTH-1:0];
    w_satNext  = 1'b0;
    if (SAT_MODE != 0) begin
      if (w_over) begin
        w_doutNext = RES_SIGNED ? SMAX[dout_WIDTH-1:0] : UMAX[dout_WIDTH-1:0];
        w_satNext  = 1'b1;
      end else if (w_under) begin
        w_doutNext = SMIN[dout_WIDTH-1:0];
        w_satNext  = 1'b1;
      end
    end
  end

  // The result registers load together with the last valid bit, so dout and
  // sat_flag stay put for as long as a beat waits on out_ready.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else if (w_load[N-1] && w_vIn[N-1]) begin
      r_dout <= w_doutNext;
      r_sat  <= w_satNext;
    end
  end

  assign o_out_valid = r_valid[N-1];
  assign o_dout      = r_dout;
  assign o_sat_flag  = r_sat;

endmodule

// File: tb/tb_case_9_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// tb_case_9_mul_pipe_hs
//   Self-checking bench for case_9_mul_pipe_hs. Five instances share the same
//   stimulus: the default configuration, a 14-bit saturating and a 14-bit
//   wrapping output, an unsigned din1 and a 4-bit output shift. The default
//   instance's handshake drives a scoreboard of expected products; the other
//   instances are checked against hand-computed single-beat results.
// ---------------------------------------------------------------------------
module tb_case_9_mul_pipe_hs;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic inValid;
  logic signed [13:0] din0;
  logic signed [11:0] din1;
  logic outReady;

  logic        inReadyDef, outValidDef, satDef;
  logic [25:0] doutDef;
  logic        inReadySat, outValidSat, satSat;
  logic [13:0] doutSat;
  logic        inReadyWrap, outValidWrap, satWrap;
  logic [13:0] doutWrap;
  logic        inReadyUns, outValidUns, satUns;
  logic [25:0] doutUns;
  logic        inReadyShf, outValidShf, satShf;
  logic [25:0] doutShf;

  int checks   = 0;
  int errors   = 0;
  int popCount = 0;
  int sbQueue[$];
  bit lastOv;
  bit lastInReady;

  always #5 clk = ~clk;

  case_9_mul_pipe_hs u_dut (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_in_valid(inValid), .o_in_ready(inReadyDef),
    .i_din0(din0), .i_din1(din1), .o_out_valid(outValidDef), .i_out_ready(outReady),
    .o_dout(doutDef), .o_sat_flag(satDef)
  );

  case_9_mul_pipe_hs #(.dout_WIDTH(14), .SAT_MODE(1)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_in_valid(inValid), .o_in_ready(inReadySat),
    .i_din0(din0), .i_din1(din1), .o_out_valid(outValidSat), .i_out_ready(outReady),
    .o_dout(doutSat), .o_sat_flag(satSat)
  );

  case_9_mul_pipe_hs #(.dout_WIDTH(14), .SAT_MODE(0)) u_wrap (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_in_valid(inValid), .o_in_ready(inReadyWrap),
    .i_din0(din0), .i_din1(din1), .o_out_valid(outValidWrap), .i_out_ready(outReady),
    .o_dout(doutWrap), .o_sat_flag(satWrap)
  );

  case_9_mul_pipe_hs #(.SIGNED1(0)) u_uns (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_in_valid(inValid), .o_in_ready(inReadyUns),
    .i_din0(din0), .i_din1(din1), .o_out_valid(outValidUns), .i_out_ready(outReady),
    .o_dout(doutUns), .o_sat_flag(satUns)
  );

  case_9_mul_pipe_hs #(.OUT_SHIFT(4)) u_shf (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_in_valid(inValid), .o_in_ready(inReadyShf),
    .i_din0(din0), .i_din1(din1), .o_out_valid(outValidShf), .i_out_ready(outReady),
    .o_dout(doutShf), .o_sat_flag(satShf)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, predicts the transfers at the coming edge
  // from the handshake, and checks every beat that leaves the default
  // instance against the scoreboard. Returns one ns after that edge.
  task automatic applyStimulus(input bit v, input int a, input int b, input bit rdy,
                               input bit ceIn, output bit acc);
    int expVal;
    inValid  = v;
    din0     = 14'(a);
    din1     = 12'(b);
    outReady = rdy;
    ce       = ceIn;
    #1;
    lastOv      = outValidDef;
    lastInReady = inReadyDef;
    if (outValidDef && outReady && ce) begin
      popCount++;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        expVal = sbQueue.pop_front();
        checkOutput("dout_stream", int'($signed(doutDef)), expVal);
      end
    end
    acc = inValid && inReadyDef;
    if (acc) sbQueue.push_back(int'(din0) * int'(din1));
    @(posedge clk);
    #1;
  endtask

  // Sends one beat and idles with out_ready high until it shows on the output.
  task automatic runSingle(input int a, input int b);
    bit acc;
    int waitCnt;
    waitCnt = 0;
    applyStimulus(1'b1, a, b, 1'b1, 1'b1, acc);
    checkOutput("single_accept", int'(acc), 1);
    while (!outValidDef && waitCnt < 10) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
      waitCnt++;
    end
    checkOutput("single_out_valid", int'(outValidDef), 1);
  endtask

  initial begin
    bit acc;
    int accCnt;
    int seenOv;
    int pop0;
    int guard;
    int staleCnt;

    reset    = 1'b1;
    ce       = 1'b1;
    inValid  = 1'b0;
    din0     = '0;
    din1     = '0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", int'(outValidDef), 0);
    checkOutput("reset_dout", int'(doutDef), 0);
    checkOutput("reset_sat", int'(satSat), 0);
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", int'(inReadyDef), 1);

    $display("[TB] single beat latency and signedness");
    applyStimulus(1'b1, 100, -3, 1'b1, 1'b1, acc);
    checkOutput("t1_accept", int'(acc), 1);
    checkOutput("t1_ov_cycle1", int'(outValidDef), 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
    checkOutput("t1_ov_cycle2", int'(outValidDef), 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
    checkOutput("t1_ov_cycle3", int'(outValidDef), 1);
    checkOutput("t1_dout", int'($signed(doutDef)), -300);
    checkOutput("t1_sat", int'(satDef), 0);
    checkOutput("t1_shift_dout", int'($signed(doutShf)), -19);
    checkOutput("t1_sat14_dout", int'($signed(doutSat)), -300);
    checkOutput("t1_sat14_flag", int'(satSat), 0);
    checkOutput("t1_uns_dout", int'($signed(doutUns)), 409300);

    runSingle(-1, 4095);
    checkOutput("t4_uns_dout", int'($signed(doutUns)), -4095);
    checkOutput("t4_def_dout", int'($signed(doutDef)), 1);

    $display("[TB] saturate and wrap narrowing");
    runSingle(100, 100);
    checkOutput("t3_sat_pos_dout", int'($signed(doutSat)), 8191);
    checkOutput("t3_sat_pos_flag", int'(satSat), 1);
    checkOutput("t3_wrap_pos_dout", int'($signed(doutWrap)), -6384);
    checkOutput("t3_wrap_pos_flag", int'(satWrap), 0);
    checkOutput("t3_def_dout", int'($signed(doutDef)), 10000);
    runSingle(-8192, 3);
    checkOutput("t3_sat_neg_dout", int'($signed(doutSat)), -8192);
    checkOutput("t3_sat_neg_flag", int'(satSat), 1);
    checkOutput("t3_wrap_neg_dout", int'($signed(doutWrap)), -8192);
    checkOutput("t3_wrap_neg_flag", int'(satWrap), 0);

    $display("[TB] extreme operands and 20 back-to-back beats");
    runSingle(-8192, -2048);
    checkOutput("t2_dout_max", int'($signed(doutDef)), 16777216);
    seenOv = 0;
    pop0   = popCount;
    for (int c = 0; c < 23; c++) begin
      if (c < 20) applyStimulus(1'b1, c * 37 - 300, 50 - c * 7, 1'b1, 1'b1, acc);
      else        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
      if (c >= 3 && lastOv) seenOv++;
    end
    checkOutput("t2_no_gap", seenOv, 20);
    checkOutput("t2_pops", popCount - pop0, 21);
    checkOutput("t2_queue_empty", sbQueue.size(), 0);

    $display("[TB] backpressure");
    accCnt = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(accCnt < 5, accCnt + 1, 1, 1'b0, 1'b1, acc);
      if (acc) accCnt++;
    end
    checkOutput("t5_accepted_stalled", accCnt, 3);
    checkOutput("t5_in_ready_stalled", int'(lastInReady), 0);
    checkOutput("t5_dout_held", int'($signed(doutDef)), 1);
    guard = 0;
    while ((accCnt < 5 || sbQueue.size() != 0) && guard < 20) begin
      applyStimulus(accCnt < 5, accCnt + 1, 1, 1'b1, 1'b1, acc);
      if (acc) accCnt++;
      guard++;
    end
    checkOutput("t5_accepted_total", accCnt, 5);
    checkOutput("t5_drained", sbQueue.size(), 0);

    // A, bubble, B, C with the output stalled: the bubble must be squeezed out.
    accCnt = 0;
    applyStimulus(1'b1, 7, -2, 1'b0, 1'b1, acc);
    if (acc) accCnt++;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 9, 9, 1'b0, 1'b1, acc);
    if (acc) accCnt++;
    applyStimulus(1'b1, -5, -5, 1'b0, 1'b1, acc);
    if (acc) accCnt++;
    checkOutput("t5_bubble_accepted", accCnt, 3);
    applyStimulus(1'b1, 11, 1, 1'b0, 1'b1, acc);
    checkOutput("t5_bubble_full", int'(acc), 0);
    checkOutput("t5_bubble_head", int'($signed(doutDef)), -14);
    guard = 0;
    while (sbQueue.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
      guard++;
    end
    checkOutput("t5_bubble_drained", sbQueue.size(), 0);

    $display("[TB] reset mid-stream");
    // One beat parked at the output with two more behind it.
    applyStimulus(1'b1, 3, 4, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 5, 6, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 2, 2, 1'b0, 1'b1, acc);
    checkOutput("t6_pre_ov", int'(outValidDef), 1);
    checkOutput("t6_pre_dout", int'($signed(doutDef)), 12);
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_ov", int'(outValidDef), 0);
    checkOutput("t6_reset_dout", int'(doutDef), 0);
    sbQueue.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    #1;
    checkOutput("t6_in_ready", int'(inReadyDef), 1);
    staleCnt = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
      if (outValidDef) staleCnt++;
    end
    checkOutput("t6_no_stale", staleCnt, 0);

    $display("[TB] clock enable freeze");
    applyStimulus(1'b1, 21, 2, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, -13, 3, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
    checkOutput("t6_ce_pre_ov", int'(outValidDef), 1);
    checkOutput("t6_ce_pre_dout", int'($signed(doutDef)), 42);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1, 1, 1'b1, 1'b0, acc);
      checkOutput("t6_ce_in_ready", int'(lastInReady), 0);
      checkOutput("t6_ce_ov_held", int'(outValidDef), 1);
      checkOutput("t6_ce_dout_held", int'($signed(doutDef)), 42);
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
    checkOutput("t6_ce_latency_ov", int'(outValidDef), 1);
    checkOutput("t6_ce_latency_dout", int'($signed(doutDef)), -39);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
    checkOutput("t6_ce_drained", sbQueue.size(), 0);
    checkOutput("t6_ce_final_ov", int'(outValidDef), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
